// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I size codes, FSM states
// and the request legality check used at accept time.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } lsu_state_e;

    // Stores only have signed-name codes; the unsigned variants are load-only.
    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        logic ok;
        if (we) begin
            ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            ok = (funct3 == F3_B)  || (funct3 == F3_H)  || (funct3 == F3_W) ||
                 (funct3 == F3_BU) || (funct3 == F3_HU);
        end
        return ok;
    endfunction

    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic bad;
        case (funct3[1:0])
            2'b01:   bad = addr_lo[0];
            2'b10:   bad = (addr_lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic access_err(input logic we, input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
        return !funct3_legal(we, funct3) || misaligned(funct3, addr_lo);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend and store read-modify-merge
// for a little-endian 32-bit word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // NOTE: every output of a combinational block is given a default first so
    // that no path through the case statements can infer a latch.
    always_comb begin
        byte_lane  = 8'h00;
        half_lane  = 16'h0000;
        load_data  = 32'h0;
        store_word = word;

        case (addr_lo)
            2'd0:    byte_lane = word[7:0];
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        half_lane = addr_lo[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
            F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
            F3_W:    load_data = word;
            F3_BU:   load_data = {24'h0, byte_lane};
            F3_HU:   load_data = {16'h0, half_lane};
            default: load_data = 32'h0;
        endcase

        case (funct3)
            F3_B: begin
                case (addr_lo)
                    2'd0:    store_word[7:0]   = wdata[7:0];
                    2'd1:    store_word[15:8]  = wdata[7:0];
                    2'd2:    store_word[23:16] = wdata[7:0];
                    default: store_word[31:24] = wdata[7:0];
                endcase
            end
            F3_H: begin
                if (addr_lo[1]) store_word[31:16] = wdata[15:0];
                else            store_word[15:0]  = wdata[15:0];
            end
            F3_W:    store_word = wdata;
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time against a combinational-read,
// clocked-write data memory. Sub-word stores are done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32   // lane logic is written for 32 only
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_A,
    output logic [DATA_W-1:0] mem_WD,
    output logic              mem_WE,
    input  logic [DATA_W-1:0] mem_RD
);

    lsu_state_e        state;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] store_word;
    logic              req_fire;
    logic              req_bad;

    assign req_ready = (state == IDLE);
    assign req_fire  = req_valid && req_ready;
    assign req_bad   = access_err(req_we, req_funct3, req_addr[1:0]);

    // Decoded purely from registers, so reset drives it to 0 immediately.
    assign mem_A = ((state == ACCESS) || (state == WRITE)) ?
                   {addr_q[ADDR_W-1:2], 2'b00} : '0;

    lsu_align u_align (
        .funct3     (funct3_q),
        .addr_lo    (addr_q[1:0]),
        .word       (mem_RD),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            funct3_q  <= 3'b000;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            mem_WE    <= 1'b0;
            mem_WD    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        we_q      <= req_we;
                        funct3_q  <= req_funct3;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        rsp_rdata <= '0;
                        // Illegal requests skip memory entirely and answer next cycle.
                        rsp_err   <= req_bad;
                        rsp_valid <= req_bad;
                        state     <= req_bad ? RESP : ACCESS;
                    end
                end
                ACCESS: begin
                    if (we_q) begin
                        mem_WD <= store_word;
                        mem_WE <= 1'b1;
                        state  <= WRITE;
                    end else begin
                        rsp_rdata <= load_data;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                WRITE: begin
                    mem_WE    <= 1'b0;
                    mem_WD    <= '0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 32: byte-address width.
REQ-002 Parameter DATA_W, default 32: word width; only 32 is supported.
REQ-003 clk  input  1: single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1: reset, asynchronous assertion, active-low.
REQ-005 req_valid  input  1: core presents a memory request.
REQ-006 req_ready  output  1: unit accepts a request; high only in IDLE.
REQ-007 req_we  input  1: 1 = store, 0 = load.
REQ-008 req_funct3  input  3: RV32I size code; loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
REQ-009 req_addr  input  ADDR_W: byte address (ALU result).
REQ-010 req_wdata  input  DATA_W: store data (rs2), right-aligned.
REQ-011 rsp_valid  output  1: response available.
REQ-012 rsp_ready  input  1: core consumes the response.
REQ-013 rsp_rdata  output  DATA_W: extended load data; 0 for stores and errors.
REQ-014 rsp_err  output  1: misaligned access or illegal funct3.
REQ-015 mem_A  output  ADDR_W: word-aligned address to Data_Memory (low 2 bits 0).
REQ-016 mem_WD  output  DATA_W: merged write word to Data_Memory.
REQ-017 mem_WE  output  1: write enable to Data_Memory; Data_Memory writes on the clk edge.
REQ-018 mem_RD  input  DATA_W: combinational read word from Data_Memory at mem_A.

Function
REQ-019 The FSM SHALL have states IDLE, ACCESS, WRITE, RESP.
REQ-020 A request SHALL be accepted on the edge where req_valid && req_ready, latching we, funct3, addr and wdata.
REQ-021 On accept, an illegal funct3 (loads 011/11x; stores other than 000/001/010) or a misaligned access (halfword with addr[0]=1, word with addr[1:0]!=0) SHALL go IDLE->RESP with rsp_err=1, with no memory access and mem_WE never asserted.
REQ-022 A legal request SHALL go IDLE->ACCESS. mem_A SHALL equal {addr[ADDR_W-1:2],2'b00} in ACCESS and WRITE, and 0 otherwise.
REQ-023 Load in ACCESS: select the byte or halfword lane from mem_RD by addr[1:0]; sign-extend for LB/LH, zero-extend for LBU/LHU; register into rsp_rdata; go to RESP. Latency is 2 cycles from accept to rsp_valid.
REQ-024 Store in ACCESS: register mem_RD with the target lanes replaced by req_wdata[7:0] or [15:0]; SW replaces all 4 lanes. Then go to WRITE.
REQ-025 WRITE SHALL assert mem_WE for exactly one cycle with mem_WD = the merged word, then go to RESP. Latency is 3 cycles from accept to rsp_valid.
REQ-026 rsp_valid SHALL be high only in RESP, and rsp_rdata and rsp_err SHALL hold stable until rsp_ready. RESP->IDLE on rsp_ready.
REQ-027 req_ready SHALL be combinationally 1 in IDLE only. A request held during RESP SHALL be accepted no earlier than the cycle after the RESP handshake.
REQ-028 mem_WE SHALL be 0 in every state except WRITE, and mem_WD SHALL be 0 outside WRITE.
REQ-029 Address wrap SHALL NOT be detected; mem_A is the truncated word address.

Reset
REQ-030 rst_n low SHALL force, asynchronously and in any state including WRITE, the following: state IDLE, mem_WE 0, rsp_valid 0, rsp_err 0, rsp_rdata 0, mem_A 0, mem_WD 0, and all latched request fields 0.
REQ-031 A request in flight at reset SHALL be dropped with no response. If reset arrives in WRITE before the edge, no write occurs.
REQ-032 After rst_n rises, req_ready SHALL be 1 on the first cycle.

Structure
REQ-033 Package lsu_pkg SHALL hold the funct3 constants and the state enum (IDLE, ACCESS, WRITE, RESP).
REQ-034 Sub-module lsu_align SHALL be purely combinational: it performs load lane extract/extend and store lane merge from (funct3, addr[1:0], word, wdata).

Verification
REQ-035 Reset, then SW addr 20 data DEADBEEF -> mem_WE one cycle with mem_A 20, mem_WD DEADBEEF; rsp_valid 3 cycles after accept; then LW 20 -> rsp_rdata DEADBEEF.
REQ-036 SW 32 = CAFEBABE, then SB addr 33 data 000000AA -> mem_WD CAFEAABE; then LB 33 -> FFFFFFAA; LBU 33 -> 000000AA.
REQ-037 SH addr 22 data 00008001 over DEADBEEF at word 20 -> word 8001BEEF; LH 22 -> FFFF8001; LHU 22 -> 00008001.
REQ-038 LW addr 21, SH addr 23, and load funct3 011 -> rsp_err 1, rsp_rdata 0, mem_WE never asserted, 1 cycle from accept to response.
REQ-039 Hold rsp_ready low for 5 cycles in RESP -> rsp_valid and rsp_rdata stable and req_ready 0 throughout; back-to-back requests are accepted only after the handshake.
REQ-040 Assert rst_n low in WRITE before the edge -> mem_WE drops immediately, the word is unchanged on reread, and req_ready is 1 after release.
